apb_rr_arbiter: RTL

Round-robin arbiter sharing the single user APB register master port among NUM_REQ independent APB requesters, e.g. the HOLOLINK control plane and a local board-init sequencer. It sits between the requesters and the user register fabric in the i_apb_clk domain. Each requester sees a standard APB completer. Only one transfer is ever outstanding on the master port.

---
 rtl/apb_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 25 ++
 rtl/apb_rr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB round-robin arbiter.
package apb_arb_pkg;

  localparam int unsigned APB_AW             = 32;
  localparam int unsigned APB_DW             = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Command captured from the winning requester.
  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic              write;
  } apb_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner, searching from last_grant+1 with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[IDX_W'((32'(last_grant) + i) % NUM_REQ)]) begin
        gnt[IDX_W'((32'(last_grant) + i) % NUM_REQ)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ APB requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      i_apb_clk,
  input  logic                      i_apb_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_psel,
  input  logic [NUM_REQ-1:0]        i_req_penable,
  input  logic [APB_AW*NUM_REQ-1:0] i_req_paddr,
  input  logic [APB_DW*NUM_REQ-1:0] i_req_pwdata,
  input  logic [NUM_REQ-1:0]        i_req_pwrite,
  output logic [NUM_REQ-1:0]        o_req_pready,
  output logic [APB_DW-1:0]         o_req_prdata,
  output logic                      o_req_pserr,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  output logic                      o_apb_pwrite,
  output logic [APB_AW-1:0]         o_apb_paddr,
  output logic [APB_DW-1:0]         o_apb_pwdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pserr,
  input  logic [APB_DW-1:0]         i_apb_prdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d, grant_idx;
  logic [NUM_REQ-1:0]  win, grant_d, pready_d;
  apb_cmd_t            cmd_q, cmd_d, win_cmd;
  logic                psel_d, penable_d, pserr_d;
  logic [APB_DW-1:0]   prdata_d;

  // penable is not part of arbitration; TIMEOUT_CYCLES only matters with the timeout build.
  logic unused_ok;
  assign unused_ok = ^{i_req_penable, (TIMEOUT_CYCLES != 0)};

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (i_req_psel),
    .last_grant (last_q),
    .gnt        (win)
  );

  // Winner's command mux.
  always_comb begin
    win_cmd = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (win[r]) begin
        win_cmd.addr  = i_req_paddr[r*APB_AW +: APB_AW];
        win_cmd.wdata = i_req_pwdata[r*APB_DW +: APB_DW];
        win_cmd.write = i_req_pwrite[r];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (o_grant[r]) grant_idx = IDX_W'(r);
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = o_grant;
    cmd_d     = cmd_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pready_d  = '0;
    prdata_d  = '0;
    pserr_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|i_req_psel) begin
          state_d = SETUP;
          grant_d = win;
          cmd_d   = win_cmd;
          psel_d  = 1'b1;
        end else begin
          grant_d = '0;
          cmd_d   = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (i_apb_pready) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cmd_d     = '0;
          pready_d  = o_grant;
          prdata_d  = i_apb_prdata;
          pserr_d   = i_apb_pserr;
          last_d    = grant_idx;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cmd_d     = '0;
          pready_d  = o_grant;
          pserr_d   = 1'b1;
          last_d    = grant_idx;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      state_q       <= IDLE;
      last_q        <= IDX_W'(NUM_REQ - 1);
      cmd_q         <= '0;
      o_grant       <= '0;
      o_busy        <= 1'b0;
      o_apb_psel    <= 1'b0;
      o_apb_penable <= 1'b0;
      o_req_pready  <= '0;
      o_req_prdata  <= '0;
      o_req_pserr   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cmd_q         <= cmd_d;
      o_grant       <= grant_d;
      o_busy        <= (state_d != IDLE);
      o_apb_psel    <= psel_d;
      o_apb_penable <= penable_d;
      o_req_pready  <= pready_d;
      o_req_prdata  <= prdata_d;
      o_req_pserr   <= pserr_d;
    end
  end

  assign o_apb_paddr  = cmd_q.addr;
  assign o_apb_pwdata = cmd_q.wdata;
  assign o_apb_pwrite = cmd_q.write;

endmodule
